// File: rtl/decompressor_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module      : decompressor_unpacker_if
//  Description : Chunk-in / word-pair-out handshake bundle for the unpacker.
//  Revision    : 1.0  initial release
// ============================================================================
interface decompressor_unpacker_if #(
    parameter int WIDTH      = 64,
    parameter int DICT_ENTRY = 16,
    parameter int DICT_WORD  = 32
);
    logic                            i_valid;
    logic                            o_ready;
    logic [WIDTH-1:0]                i_data;
    logic                            i_raw;
    logic                            i_last;
    logic                            o_valid;
    logic                            i_ready;
    logic [WIDTH-1:0]                o_word;
    logic                            o_last;
    logic                            o_err;
    logic [DICT_WORD*DICT_ENTRY-1:0] o_dictionary_data;

    modport slave (
        input  i_valid, i_data, i_raw, i_last, i_ready,
        output o_ready, o_valid, o_word, o_last, o_err, o_dictionary_data
    );

    modport master (
        output i_valid, i_data, i_raw, i_last, i_ready,
        input  o_ready, o_valid, o_word, o_last, o_err, o_dictionary_data
    );
endinterface
`default_nettype wire

// File: rtl/decompressor_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : decompressor_unpacker
//  Description : Extracts MSB-first variable-length codes from a bit buffer,
//                rebuilds words against a FIFO dictionary, emits word pairs.
//  Revision    : 1.0  initial release
// ============================================================================
module decompressor_unpacker #(
    parameter int WIDTH      = 64,
    parameter int DICT_ENTRY = 16,
    parameter int DICT_WORD  = 32,
    parameter int CACHE_LINE = 128,
    parameter int BUF_WIDTH  = 128
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    decompressor_unpacker_if.slave bus
);
    localparam int              c_WORDS     = CACHE_LINE / DICT_WORD;
    localparam int              c_CW        = $clog2(BUF_WIDTH + 1);
    localparam logic [c_CW-1:0] c_CHUNK     = c_CW'(WIDTH);
    localparam logic [c_CW-1:0] c_ROOM      = c_CW'(BUF_WIDTH - WIDTH);
    localparam logic [1:0]      c_LAST_WORD = 2'(c_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_RAW    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                                r_state, w_state_nxt;
    logic [BUF_WIDTH-1:0]                  r_buf;
    logic [c_CW-1:0]                       r_cnt;
    logic [1:0]                            r_wcnt;
    logic [DICT_WORD-1:0]                  r_hold;
    logic [WIDTH-1:0]                      r_word;
    logic                                  r_valid, r_last, r_err, r_last_seen;
    logic [DICT_ENTRY-1:0][DICT_WORD-1:0]  r_dict;
    logic [3:0]                            r_ptr;

    logic [33:0]          w_head;
    logic [c_CW-1:0]      w_len, w_take, w_keep, w_cnt_nxt;
    logic [DICT_WORD-1:0] w_dec;
    logic                 w_push, w_rsv, w_accept, w_slot, w_append;
    logic                 w_clear, w_err_nxt, w_load, w_load_last, w_hold_en;
    logic                 w_push_en, w_seen_clr;
    logic [WIDTH-1:0]     w_load_word;
    logic [1:0]           w_wcnt_nxt;
    logic [BUF_WIDTH-1:0] w_chunk_ext, w_buf_nxt;

    // Valid bits sit MSB-aligned; bits below the count are always zero.
    assign w_head      = r_buf[BUF_WIDTH-1 -: 34];
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_slot      = !r_valid || bus.i_ready;
    assign w_chunk_ext = {bus.i_data, {(BUF_WIDTH-WIDTH){1'b0}}};
    assign w_keep      = r_cnt - w_take;
    assign w_buf_nxt   = (r_buf << w_take) | (w_append ? (w_chunk_ext >> w_keep) : '0);
    assign w_cnt_nxt   = w_keep + (w_append ? c_CHUNK : '0);

    always_comb begin
        w_len  = '0;
        w_dec  = '0;
        w_push = 1'b0;
        w_rsv  = 1'b0;
        case (w_head[33:32])
            2'b00: w_len = c_CW'(2);
            2'b01: begin
                w_len  = c_CW'(34);
                w_dec  = w_head[31:0];
                w_push = 1'b1;
            end
            2'b10: begin
                w_len = c_CW'(6);
                w_dec = r_dict[w_head[31:28]];
            end
            default: begin
                case (w_head[31:30])
                    2'b00: begin
                        w_len  = c_CW'(24);
                        w_dec  = {r_dict[w_head[29:26]][31:16], w_head[25:10]};
                        w_push = 1'b1;
                    end
                    2'b01: begin
                        w_len = c_CW'(12);
                        w_dec = {24'b0, w_head[29:22]};
                    end
                    2'b10: begin
                        w_len  = c_CW'(16);
                        w_dec  = {r_dict[w_head[29:26]][31:8], w_head[25:18]};
                        w_push = 1'b1;
                    end
                    default: begin
                        w_len = c_CW'(4);
                        w_rsv = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = '0;
        w_clear     = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        w_load_word = '0;
        w_load_last = 1'b0;
        w_hold_en   = 1'b0;
        w_push_en   = 1'b0;
        w_wcnt_nxt  = r_wcnt;
        w_seen_clr  = 1'b0;
        w_append    = w_accept && (r_state != S_DRAIN);
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = bus.i_raw ? S_RAW : S_DECODE;
            end
            S_DECODE: begin
                if (w_rsv || (r_last_seen && (r_cnt < w_len))) begin
                    w_err_nxt   = 1'b1;
                    w_clear     = 1'b1;
                    w_seen_clr  = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else if ((r_cnt >= w_len) && (!r_wcnt[0] || w_slot)) begin
                    w_take     = w_len;
                    w_push_en  = w_push;
                    w_wcnt_nxt = r_wcnt + 2'd1;
                    if (r_wcnt[0]) begin
                        w_load      = 1'b1;
                        w_load_word = {w_dec, r_hold};
                        w_load_last = (r_wcnt == c_LAST_WORD);
                    end else begin
                        w_hold_en = 1'b1;
                    end
                    if (r_wcnt == c_LAST_WORD)
                        w_state_nxt = S_DRAIN;
                end
            end
            S_RAW: begin
                // Raw chunks queue through the buffer so none is lost under backpressure.
                if ((r_cnt >= c_CHUNK) && w_slot) begin
                    w_take      = c_CHUNK;
                    w_load      = 1'b1;
                    w_load_word = r_buf[BUF_WIDTH-1 -: WIDTH];
                    if (r_last_seen && (r_cnt == c_CHUNK)) begin
                        w_load_last = 1'b1;
                        w_seen_clr  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (r_last_seen) begin
                    w_clear     = 1'b1;
                    w_seen_clr  = 1'b1;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf       <= '0;
            r_cnt       <= '0;
            r_wcnt      <= '0;
            r_hold      <= '0;
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
            r_last_seen <= 1'b0;
            r_dict      <= '0;
            r_ptr       <= '0;
        end else begin
            r_buf  <= w_clear ? '0 : w_buf_nxt;
            r_cnt  <= w_clear ? '0 : w_cnt_nxt;
            r_wcnt <= w_wcnt_nxt;
            r_err  <= w_err_nxt;
            if (w_hold_en) r_hold <= w_dec;
            if (w_load) begin
                r_word  <= w_load_word;
                r_valid <= 1'b1;
                r_last  <= w_load_last;
            end else if (bus.i_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            if (w_seen_clr)                  r_last_seen <= 1'b0;
            else if (w_accept && bus.i_last) r_last_seen <= 1'b1;
            if (w_push_en) begin
                r_dict[r_ptr] <= w_dec;
                r_ptr         <= r_ptr + 4'd1;
            end
        end
    end

    assign bus.o_ready           = (r_cnt <= c_ROOM) && !r_last_seen;
    assign bus.o_valid           = r_valid;
    assign bus.o_word            = r_word;
    assign bus.o_last            = r_last;
    assign bus.o_err             = r_err;
    assign bus.o_dictionary_data = r_dict;
endmodule
`default_nettype wire

// File: tb/tb_decompressor_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decompressor_unpacker
//  Description : Directed and randomized bench with a code-table encoder model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decompressor_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decompressor_unpacker_if bus ();
    decompressor_unpacker dut (.i_clk(clk), .i_reset(rst), .bus(bus));

    int          total = 0;
    int          bad = 0;
    int          err_pulses = 0;
    bit          bp_on = 1'b0;
    bit          rdy_force = 1'b1;
    logic [64:0] obs_q[$];
    logic [64:0] exp_q[$];
    bit          gq[$];
    logic [31:0] wl[$];
    logic [31:0] m_dict[16];
    int          m_ptr = 0;

    always @(negedge clk) begin
        bus.i_ready = bp_on ? ($urandom_range(0, 3) != 0) : rdy_force;
        if (!rst) begin
            if (bus.o_valid && bus.i_ready) obs_q.push_back({bus.o_last, bus.o_word});
            if (bus.o_err) err_pulses++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_raw = 1'b0; bus.i_last = 1'b0; bus.i_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) m_dict[i] = '0;
        m_ptr = 0;
        gq.delete(); wl.delete(); obs_q.delete(); exp_q.delete();
        err_pulses = 0;
    endtask

    task automatic send(input logic [63:0] d, input bit raw, input bit last);
        int t = 0;
        bus.i_valid = 1'b1; bus.i_data = d; bus.i_raw = raw; bus.i_last = last;
        @(negedge clk);
        while (!bus.o_ready && t < 300) begin @(negedge clk); t++; end
        chk("send_ready", 128'(t < 300), 128'd1);
        @(posedge clk);
        #1 bus.i_valid = 1'b0; bus.i_raw = 1'b0; bus.i_last = 1'b0;
    endtask

    task automatic put(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) gq.push_back(v[i]);
    endtask

    // Encodes one word per the code table and tracks the decoded value and dictionary.
    task automatic enc(input int kind, input logic [31:0] lit, input logic [3:0] idx);
        logic [31:0] w;
        bit          push;
        push = 1'b0;
        case (kind)
            1:       begin put(32'b01, 2);   put(lit, 32); w = lit; push = 1'b1; end
            2:       begin put(32'b10, 2);   put(32'(idx), 4); w = m_dict[idx]; end
            3:       begin put(32'hC, 4); put(32'(idx), 4); put(lit, 16);
                           w = {m_dict[idx][31:16], lit[15:0]}; push = 1'b1; end
            4:       begin put(32'hD, 4); put(lit, 8); w = {24'h0, lit[7:0]}; end
            5:       begin put(32'hE, 4); put(32'(idx), 4); put(lit, 8);
                           w = {m_dict[idx][31:8], lit[7:0]}; push = 1'b1; end
            default: begin put(32'b00, 2); w = '0; end
        endcase
        if (push) begin m_dict[m_ptr] = w; m_ptr = (m_ptr + 1) % 16; end
        wl.push_back(w);
    endtask

    task automatic flush_line();
        logic [63:0] c;
        exp_q.push_back({1'b0, wl[1], wl[0]});
        exp_q.push_back({1'b1, wl[3], wl[2]});
        wl.delete();
        while (gq.size() > 0) begin
            for (int i = 63; i >= 0; i--) c[i] = (gq.size() > 0) ? gq.pop_front() : 1'b0;
            send(c, 1'b0, gq.size() == 0);
        end
    endtask

    task automatic raw_line(input logic [63:0] d1, input logic [63:0] d2);
        exp_q.push_back({1'b0, d1});
        exp_q.push_back({1'b1, d2});
        send(d1, 1'b1, 1'b0);
        send(d2, 1'b1, 1'b1);
    endtask

    task automatic mixed_line();
        enc(1, 32'hDEADBEEF, 4'd0);
        enc(2, 32'h0, 4'd0);
        enc(3, 32'h1234, 4'd0);
        enc(4, 32'h5A, 4'd0);
        flush_line();
    endtask

    task automatic drain_check(input string tag);
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 4000) begin @(negedge clk); t++; end
        chk({tag, "_timeout"}, 128'(t < 4000), 128'd1);
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic dict_check(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, bus.o_dictionary_data[32*i +: 32], m_dict[i]);
    endtask

    initial begin
        logic [31:0] lit17;
        int          t;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_raw = 1'b0; bus.i_last = 1'b0;
        reset_dut();
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_err",   bus.o_err,   1'b0);
        chk("rst_last",  bus.o_last,  1'b0);
        chk("rst_word",  bus.o_word,  64'h0);
        chk("rst_dict",  128'(bus.o_dictionary_data != '0), 128'd0);

        repeat (4) enc(0, 32'h0, 4'd0);
        flush_line();
        drain_check("zero_line");

        mixed_line();
        drain_check("mixed");
        chk("mixed_dict0", bus.o_dictionary_data[31:0],  32'hDEADBEEF);
        chk("mixed_dict1", bus.o_dictionary_data[63:32], 32'hDEAD1234);

        rdy_force = 1'b0;
        mixed_line();
        t = 0;
        while (!bus.o_valid && t < 100) begin @(negedge clk); t++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_word",  bus.o_word,  64'hDEADBEEF_DEADBEEF);
            chk("bp_valid", bus.o_valid, 1'b1);
            chk("bp_ready", bus.o_ready, 1'b0);
        end
        @(posedge clk);
        #1 rdy_force = 1'b1;
        drain_check("backpressure");

        raw_line(64'h1111111111111111, 64'h2222222222222222);
        drain_check("raw");
        dict_check("raw_dict");

        send(64'hF000_0000_0000_0000, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("err_pulses", 128'(err_pulses), 128'd1);
        chk("err_no_out", 128'(obs_q.size()), 128'd0);
        repeat (4) enc(0, 32'h0, 4'd0);
        flush_line();
        drain_check("post_err");

        send({2'b01, 32'hCAFEF00D, 30'b0}, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        reset_dut();
        chk("midrst_valid", bus.o_valid, 1'b0);
        chk("midrst_ready", bus.o_ready, 1'b1);
        dict_check("midrst_dict");

        // 17 pushes wrap the write pointer back onto entry 0.
        bp_on = 1'b1;
        for (int l = 0; l < 4; l++) begin
            for (int w = 0; w < 4; w++) enc(1, $urandom, 4'd0);
            flush_line();
        end
        lit17 = $urandom;
        enc(1, lit17, 4'd0);
        repeat (3) enc(0, 32'h0, 4'd0);
        flush_line();
        drain_check("wrap");
        chk("wrap_dict0", bus.o_dictionary_data[31:0], lit17);

        for (int l = 0; l < 25; l++) begin
            if ($urandom_range(0, 4) == 0) begin
                raw_line({$urandom, $urandom}, {$urandom, $urandom});
            end else begin
                for (int w = 0; w < 4; w++)
                    enc(int'($urandom_range(0, 5)), $urandom, 4'($urandom_range(0, 15)));
                flush_line();
            end
        end
        drain_check("random");
        dict_check("random_dict");
        bp_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/decompressor_unpacker.md
Name: decompressor_unpacker

Overview:
- Decompression-side counterpart of the compress pipeline (stage 1/2 match + stage 3 packing/shifting).
- Accepts the packed compressed bitstream in 64-bit chunks and extracts variable-length codes MSB-first from a 128-bit bit buffer.
- Rebuilds each 32-bit word against a 16-entry FIFO dictionary kept in lock-step with the compressor's.
- Emits reconstructed data as 64-bit word pairs, with raw (uncompressed backup) lines passed through unchanged.

Parameters:
WIDTH, 64, input chunk and output pair width
DICT_ENTRY, 16, dictionary entries (4-bit index)
DICT_WORD, 32, dictionary/data word width
CACHE_LINE, 128, uncompressed line size (CACHE_LINE/DICT_WORD = 4 words per line)
BUF_WIDTH, 128, bit-buffer capacity

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  chunk valid
o_ready  out  1  chunk accepted when i_valid & o_ready
i_data  in  WIDTH  compressed chunk, bit 63 = first bit
i_raw  in  1  with first chunk of a line: line is stored uncompressed
i_last  in  1  marks last chunk of a line
o_valid  out  1  output pair valid
i_ready  in  1  downstream accepts pair
o_word  out  WIDTH  {word2, word1}; first decoded word in [31:0]
o_last  out  1  with final pair of a line
o_err  out  1  one-cycle pulse on decode error
o_dictionary_data  out  DICT_WORD*DICT_ENTRY  entry i at [32*i+31:32*i]

Behaviour:
- Reset: o_valid=0, o_last=0, o_err=0, o_word=0, o_ready=1. Buffer count=0. Word count=0. Dictionary all zero. Write pointer=0. FSM=IDLE. Reset mid-line abandons the line completely.
- Code table (prefix MSB-first, total length):
  - 00 zzzz: word=0, 2 bits.
  - 01 xxxx + lit32: word=lit, 34 bits, push.
  - 10 mmmm + idx4: word=dict[idx], 6 bits.
  - 1100 mmxx + idx4 + lit16: {dict[idx][31:16], lit16}, 24 bits, push.
  - 1101 zzzx + lit8: {24'b0, lit8}, 12 bits.
  - 1110 mmmx + idx4 + lit8: {dict[idx][31:8], lit8}, 16 bits, push.
  - 1111: reserved, error.
- Push: dict[wr_ptr] <= word at the clock edge; wr_ptr increments mod 16 (15 -> 0). A word decoded in the next cycle sees the pushed value.
- Input acceptance:
  - o_ready=1 when buffer count <= BUF_WIDTH-WIDTH and the line's i_last chunk has not yet been accepted.
  - An accepted chunk is appended below the existing valid bits; count += 64.
- FSM:
  - IDLE -> DECODE on a compressed chunk accept (i_raw=0).
  - IDLE -> RAW on accept with i_raw=1.
  - DECODE -> DRAIN when word 4 is decoded.
  - RAW -> IDLE after the i_last chunk's pair is loaded into the output register.
  - DRAIN -> IDLE once the i_last chunk has been accepted; the buffer is then cleared (count=0, padding discarded).
- DECODE: at most one word per cycle. A word is decoded only when count >= its code length and the pair slot can advance. Consumed bits are shifted out; count -= length.
- Pair assembly:
  - Even word index goes to a holding register.
  - Odd index loads o_word={word, hold}, o_valid=1; o_last=1 for word 4.
  - The output register loads only when o_valid=0 or i_ready=1. Otherwise decode stalls and o_word/o_valid/o_last hold stable.
- Chunks accepted in DRAIN before i_last are discarded.
- RAW: each accepted chunk is passed directly as o_word under the same output-register rule. The second chunk carries i_last and sets o_last. The dictionary is not updated. Exactly 2 chunks per raw line.
- Error (reserved prefix, or i_last consumed and count < the next code's length before word 4):
  - o_err pulses for 1 cycle.
  - Held partial pair is dropped and no o_last is emitted.
  - Buffer is cleared, word count=0, FSM -> IDLE. Dictionary pushes already made are kept.
- Latency: a chunk accepted at edge N can produce a decoded word at edge N+1. A pair is visible on o_word the cycle after its second word is decoded.
- o_dictionary_data reflects the registered dictionary contents.

Test Plan:
- Reset: i_reset high 2 cycles -> o_valid=0, o_ready=1, o_err=0, o_dictionary_data=0.
- All-zero line: i_data=64'h0, i_last=1 -> two pairs 64'h0, o_last only on second, wr_ptr stays 0.
- Mixed codes (i_ready=1):
  - Stimulus: chunk1 = 01+DEADBEEF, 10+0000, 1100+0000+1234 (exactly 64 bits); chunk2 = 1101+5A then zeros, i_last=1.
  - Response: pairs 64'hDEADBEEF_DEADBEEF then 64'h0000005A_DEAD1234 with o_last=1; dict[0]=DEADBEEF, dict[1]=DEAD1234.
- Backpressure: same stimulus with i_ready=0 for 10 cycles -> first pair stable, o_ready drops once count>64; after release, pairs are identical to the mixed-codes test with no loss or duplication.
- Raw line: i_raw=1, chunk 64'h1111111111111111, then 64'h2222222222222222 with i_last -> output pairs equal to inputs, o_last on second, dictionary unchanged.
- Error and wrap:
  - Chunk starting 1111 -> one o_err pulse, no output, next all-zero line decodes correctly.
  - 17 literal words across 5 lines -> dict[0] holds the 17th literal.
